// File: rtl/sim_bus_arbiter.sv
// sim_bus_arbiter: two-master Wishbone arbiter with stall timeout onto one shared slave
// Ports:
//   sys_clk, sys_rst            clock, synchronous active-high reset
//   m0_*/m1_* (cyc,stb,we,adr,dat_w,sel in; dat_r,ack,err out)  master 0 = ibus, master 1 = dbus
//   s_* (cyc,stb,we,adr,dat_w,sel out; dat_r,ack,err in)        shared slave
//   grant                       registered index of the current grantee
//   timeout_count               saturating count of forced-error terminations
module sim_bus_arbiter #(
   parameter int ADDR_W  = 30,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 1024
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst,
   input  logic                  m0_cyc,
   input  logic                  m0_stb,
   input  logic                  m0_we,
   input  logic [ADDR_W-1:0]     m0_adr,
   input  logic [DATA_W-1:0]     m0_dat_w,
   input  logic [DATA_W/8-1:0]   m0_sel,
   output logic [DATA_W-1:0]     m0_dat_r,
   output logic                  m0_ack,
   output logic                  m0_err,
   input  logic                  m1_cyc,
   input  logic                  m1_stb,
   input  logic                  m1_we,
   input  logic [ADDR_W-1:0]     m1_adr,
   input  logic [DATA_W-1:0]     m1_dat_w,
   input  logic [DATA_W/8-1:0]   m1_sel,
   output logic [DATA_W-1:0]     m1_dat_r,
   output logic                  m1_ack,
   output logic                  m1_err,
   output logic                  s_cyc,
   output logic                  s_stb,
   output logic                  s_we,
   output logic [ADDR_W-1:0]     s_adr,
   output logic [DATA_W-1:0]     s_dat_w,
   output logic [DATA_W/8-1:0]   s_sel,
   input  logic [DATA_W-1:0]     s_dat_r,
   input  logic                  s_ack,
   input  logic                  s_err,
   output logic                  grant,
   output logic [7:0]            timeout_count
);
   logic        grant_q, grant_d, g;
   logic [15:0] cnt_q, cnt_d, c;
   logic [7:0]  tc_q, tc_d;
   logic        pend, hit;
   always_comb begin
      // during reset the bus already looks as it will after reset: master 0, no stall history
      g        = sys_rst ? 1'b0 : grant_q;
      c        = sys_rst ? 16'd0 : cnt_q;
      s_cyc    = g ? m1_cyc   : m0_cyc;
      s_stb    = g ? m1_stb   : m0_stb;
      s_we     = g ? m1_we    : m0_we;
      s_adr    = g ? m1_adr   : m0_adr;
      s_dat_w  = g ? m1_dat_w : m0_dat_w;
      s_sel    = g ? m1_sel   : m0_sel;
      m0_dat_r = s_dat_r;
      m1_dat_r = s_dat_r;
      pend     = s_cyc & s_stb & ~s_ack & ~s_err;
      // a real slave response in the same cycle suppresses the forced error
      hit      = pend && (c == 16'(TIMEOUT));
      m0_ack   = ~g & s_ack;
      m1_ack   = g & s_ack;
      m0_err   = ~g & (s_err | hit);
      m1_err   = g & (s_err | hit);
      // hand over only when the grantee has dropped cyc and the other master wants the bus
      grant_d  = g ? ~(~m1_cyc & m0_cyc) : (~m0_cyc & m1_cyc);
      cnt_d    = (pend & ~hit) ? c + 16'd1 : 16'd0;
      tc_d     = (hit & ~&tc_q) ? tc_q + 8'd1 : tc_q;
   end
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         grant_q <= 1'b0;
         cnt_q   <= 16'd0;
         tc_q    <= 8'd0;
      end else begin
         grant_q <= grant_d;
         cnt_q   <= cnt_d;
         tc_q    <= tc_d;
      end
   end
   assign grant         = grant_q;
   assign timeout_count = tc_q;
endmodule

// File: tb/tb_sim_bus_arbiter.sv
// tb_sim_bus_arbiter: directed self-checking bench for sim_bus_arbiter with TIMEOUT=4
module tb_sim_bus_arbiter;
   logic        sys_clk = 1'b0, sys_rst = 1'b1;
   logic        m0_cyc = 0, m0_stb = 0, m0_we = 0, m1_cyc = 0, m1_stb = 0, m1_we = 0;
   logic [29:0] m0_adr = 30'h0000_0A0A, m1_adr = 30'h0000_1B1B;
   logic [31:0] m0_dat_w = 32'h1111_0000, m1_dat_w = 32'h2222_0000;
   logic [3:0]  m0_sel = 4'h3, m1_sel = 4'hC;
   logic [31:0] m0_dat_r, m1_dat_r, s_dat_r = 32'hDEAD_BEEF, s_dat_w;
   logic        m0_ack, m0_err, m1_ack, m1_err;
   logic        s_cyc, s_stb, s_we, s_ack = 0, s_err = 0, grant;
   logic [29:0] s_adr;
   logic [3:0]  s_sel;
   logic [7:0]  timeout_count;
   int cmps = 0, errs = 0;

   sim_bus_arbiter #(.ADDR_W(30), .DATA_W(32), .TIMEOUT(4)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst),
      .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr), .m0_dat_w(m0_dat_w),
      .m0_sel(m0_sel), .m0_dat_r(m0_dat_r), .m0_ack(m0_ack), .m0_err(m0_err),
      .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr), .m1_dat_w(m1_dat_w),
      .m1_sel(m1_sel), .m1_dat_r(m1_dat_r), .m1_ack(m1_ack), .m1_err(m1_err),
      .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_w(s_dat_w), .s_sel(s_sel),
      .s_dat_r(s_dat_r), .s_ack(s_ack), .s_err(s_err),
      .grant(grant), .timeout_count(timeout_count)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      cmps++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      // reset with bus idle
      tick(); tick();
      sys_rst = 0;
      chk("rst_grant", grant, 0);
      chk("rst_tc", timeout_count, 0);
      chk("rst_scyc", s_cyc, 0);
      // only m1 requests: grant moves after one edge
      m1_cyc = 1; m1_stb = 1; m1_we = 1;
      #1;
      chk("pre_grant", grant, 0);
      chk("pre_sadr", s_adr, 30'h0000_0A0A);
      tick();
      chk("g1_grant", grant, 1);
      chk("g1_sadr", s_adr, 30'h0000_1B1B);
      chk("g1_sdatw", s_dat_w, 32'h2222_0000);
      chk("g1_ssel", s_sel, 4'hC);
      chk("g1_swe", s_we, 1);
      s_ack = 1;
      #1;
      chk("g1_m1ack", m1_ack, 1);
      chk("g1_m0ack", m0_ack, 0);
      chk("dat_r0", m0_dat_r, 32'hDEAD_BEEF);
      chk("dat_r1", m1_dat_r, 32'hDEAD_BEEF);
      tick();
      s_ack = 0; m1_cyc = 0; m1_stb = 0; m1_we = 0;
      tick();
      chk("idle_hold", grant, 1);
      // m0 takes the bus, then keeps cyc over 3 strobes while m1 waits
      m0_cyc = 1; m0_stb = 1;
      tick();
      chk("g0_grant", grant, 0);
      m1_cyc = 1; m1_stb = 1;
      for (int i = 0; i < 3; i++) begin
         m0_stb = 1; s_ack = 1;
         #1;
         chk("burst_m0ack", m0_ack, 1);
         chk("burst_m1ack", m1_ack, 0);
         tick();
         chk("burst_grant_a", grant, 0);
         m0_stb = 0; s_ack = 0;
         tick();
         chk("burst_grant_b", grant, 0);
      end
      m0_cyc = 0;
      tick();
      chk("handover", grant, 1);
      chk("handover_sadr", s_adr, 30'h0000_1B1B);
      // slave never responds: forced err on the 5th pending cycle
      for (int i = 1; i <= 5; i++) begin
         #1;
         chk("to_m1err", m1_err, (i == 5) ? 1 : 0);
         chk("to_m0err", m0_err, 0);
         tick();
      end
      chk("to_count", timeout_count, 1);
      chk("to_m1err_after", m1_err, 0);
      // ack arrives exactly in the cnt==4 cycle
      repeat (4) tick();
      s_ack = 1;
      #1;
      chk("race_ack", m1_ack, 1);
      chk("race_err", m1_err, 0);
      tick();
      s_ack = 0;
      chk("race_count", timeout_count, 1);
      // slave error passes through without counting
      s_err = 1;
      #1;
      chk("serr_m1", m1_err, 1);
      chk("serr_m0", m0_err, 0);
      tick();
      s_err = 0;
      chk("serr_count", timeout_count, 1);
      // reset mid-transaction with grant=1, cnt=3
      repeat (3) tick();
      chk("pre_rst_cnt", dut.cnt_q, 3);
      chk("pre_rst_grant", grant, 1);
      sys_rst = 1;
      #1;
      chk("inrst_sadr", s_adr, 30'h0000_0A0A);
      chk("inrst_m1err", m1_err, 0);
      tick();
      sys_rst = 0;
      chk("post_rst_grant", grant, 0);
      chk("post_rst_tc", timeout_count, 0);
      chk("post_rst_cnt", dut.cnt_q, 0);
      chk("post_rst_scyc", s_cyc, 0);
      chk("post_rst_m0err", m0_err, 0);
      // continuous stall: one forced err every 5 cycles until saturation
      tick();
      chk("sat_grant", grant, 1);
      repeat (1274) tick();
      chk("sat_254", timeout_count, 254);
      tick();
      chk("sat_255", timeout_count, 255);
      repeat (4) tick();
      chk("sat_err256", m1_err, 1);
      tick();
      chk("sat_hold", timeout_count, 255);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
      $finish;
   end
endmodule
